// File: rtl/pc_sequencer_if.sv
// Command/status bundle between fetch control and the program sequencer.
// master: fetch control drives commands; slave: pc_sequencer.
interface pc_sequencer_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int REL_WIDTH  = 8,
  parameter int SP_WIDTH   = 3
);
  logic                  flash_ready;
  logic                  pc_inc;
  logic                  pc_load;
  logic                  pc_rel;
  logic                  pc_call;
  logic                  pc_ret;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [REL_WIDTH-1:0]  rel_off;
  logic                  err_clr;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic [SP_WIDTH-1:0]   sp;
  logic                  stack_full;
  logic                  stack_empty;
  logic                  stack_ovf;
  logic                  stack_unf;

  modport master (
    output flash_ready, pc_inc, pc_load, pc_rel,
    output pc_call, pc_ret, pc_next, rel_off, err_clr,
    input  pc_out, sp, stack_full, stack_empty,
    input  stack_ovf, stack_unf
  );

  modport slave (
    input  flash_ready, pc_inc, pc_load, pc_rel,
    input  pc_call, pc_ret, pc_next, rel_off, err_clr,
    output pc_out, sp, stack_full, stack_empty,
    output stack_ovf, stack_unf
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program sequencer: inc/jump/rel-branch/call/return with a return stack.
// Ports: clk, arst_n (async low), bus (pc_sequencer_if.slave).
// Define PC_REL_BRANCH_EN to build the relative-branch adder.
module pc_sequencer #(
  parameter int ADDR_WIDTH  = 12,
  parameter int STACK_DEPTH = 4,
  parameter int REL_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input logic          clk,
  input logic          arst_n,
  pc_sequencer_if.slave bus
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc_plus1;
  logic [ADDR_WIDTH-1:0] rel_tgt;
  logic [SP_W-1:0]       sp_q, sp_d;
  logic [IDX_W-1:0]      push_idx, pop_idx;
  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_WIDTH-1:0] stack_d [STACK_DEPTH];
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  full, empty;
  logic                  rel_go;

  assign pc_plus1 = pc_q + ADDR_WIDTH'(1);
  assign full     = (sp_q == SP_W'(STACK_DEPTH));
  assign empty    = (sp_q == '0);
  assign push_idx = IDX_W'(sp_q);
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

`ifdef PC_REL_BRANCH_EN
  assign rel_go  = bus.pc_rel;
  assign rel_tgt = pc_q + ADDR_WIDTH'($signed(bus.rel_off));
`else
  // No adder: pc_rel falls through to lower-priority commands.
  logic unused_rel;
  assign unused_rel = ^{bus.pc_rel, bus.rel_off};
  assign rel_go     = 1'b0;
  assign rel_tgt    = pc_q;
`endif

  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    stack_d = stack_q;
    // Clear first so a same-cycle error event below wins.
    ovf_d   = bus.err_clr ? 1'b0 : ovf_q;
    unf_d   = bus.err_clr ? 1'b0 : unf_q;
    if (bus.flash_ready) begin
      if (bus.pc_ret) begin
        if (!empty) begin
          pc_d = stack_q[pop_idx];
          sp_d = sp_q - SP_W'(1);
        end else begin
          unf_d = 1'b1;
        end
      end else if (bus.pc_call) begin
        if (!full) begin
          stack_d[push_idx] = pc_plus1;
          sp_d = sp_q + SP_W'(1);
          pc_d = bus.pc_next;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (bus.pc_load) begin
        pc_d = bus.pc_next;
      end else if (rel_go) begin
        pc_d = rel_tgt;
      end else if (bus.pc_inc) begin
        pc_d = pc_plus1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pc_q    <= RESET_VECTOR;
      sp_q    <= '0;
      stack_q <= '{default: '0};
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      stack_q <= stack_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.sp          = sp_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_ovf   = ovf_q;
  assign bus.stack_unf   = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Expected values are hand-computed for ADDR 12, depth 4, vector 0x100.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic arst_n;
  int   checks = 0;
  int   failures = 0;

  pc_sequencer_if #(.ADDR_WIDTH(12), .REL_WIDTH(8), .SP_WIDTH(3)) bus ();

  pc_sequencer #(
    .ADDR_WIDTH(12), .STACK_DEPTH(4), .REL_WIDTH(8),
    .RESET_VECTOR(12'h100)
  ) u_dut (
    .clk(clk), .arst_n(arst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.pc_inc = 0; bus.pc_load = 0; bus.pc_rel = 0;
    bus.pc_call = 0; bus.pc_ret = 0; bus.err_clr = 0;
    bus.flash_ready = 1; bus.pc_next = '0; bus.rel_off = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic chk_pc(input string nm, input logic [11:0] exp);
    checks++;
    if (bus.pc_out !== exp) begin
      failures++;
      $display("FAIL %s pc_out got %h want %h", nm, bus.pc_out, exp);
    end
  endtask

  task automatic chk_sp(input string nm, input logic [2:0] exp);
    checks++;
    if (bus.sp !== exp) begin
      failures++;
      $display("FAIL %s sp got %0d want %0d", nm, bus.sp, exp);
    end
  endtask

  task automatic chk_flags(input string nm, input logic [3:0] exp);
    checks++;
    if ({bus.stack_full, bus.stack_empty, bus.stack_ovf, bus.stack_unf} !== exp) begin
      failures++;
      $display("FAIL %s full/empty/ovf/unf got %b want %b", nm,
        {bus.stack_full, bus.stack_empty, bus.stack_ovf, bus.stack_unf}, exp);
    end
  endtask

  task automatic test_reset();
    arst_n = 1; idle();
    #1 arst_n = 0;
    #2;
    chk_pc("reset_pc", 12'h100);
    chk_sp("reset_sp", 3'd0);
    chk_flags("reset_flags", 4'b0100);
    @(negedge clk); @(negedge clk);
    arst_n = 1;
    #1;
    chk_pc("reset_release_pc", 12'h100);
  endtask

  task automatic test_inc();
    for (int i = 1; i <= 3; i++) begin
      bus.pc_inc = 1; step();
      chk_pc("inc", 12'h100 + 12'(i));
    end
    for (int i = 0; i < 2; i++) begin
      bus.flash_ready = 0; bus.pc_inc = 1; bus.pc_call = 1;
      bus.pc_next = 12'h777; step();
      chk_pc("stall_pc", 12'h103);
      chk_sp("stall_sp", 3'd0);
    end
  endtask

  task automatic test_nested_call();
    bus.pc_load = 1; bus.pc_next = 12'h010; step();
    chk_pc("load", 12'h010);
    bus.pc_call = 1; bus.pc_next = 12'h200; step();
    chk_pc("call1_pc", 12'h200); chk_sp("call1_sp", 3'd1);
    bus.pc_call = 1; bus.pc_next = 12'h300; step();
    chk_pc("call2_pc", 12'h300); chk_sp("call2_sp", 3'd2);
    bus.pc_ret = 1; step();
    chk_pc("ret1_pc", 12'h201); chk_sp("ret1_sp", 3'd1);
    bus.pc_ret = 1; step();
    chk_pc("ret2_pc", 12'h011); chk_sp("ret2_sp", 3'd0);
    chk_flags("ret2_flags", 4'b0100);
  endtask

  task automatic test_depth();
    logic [11:0] tg [4];
    logic [11:0] rp [4];
    tg = '{12'h400, 12'h500, 12'h600, 12'h700};
    rp = '{12'h601, 12'h501, 12'h401, 12'h012};
    for (int i = 0; i < 4; i++) begin
      bus.pc_call = 1; bus.pc_next = tg[i]; step();
      chk_pc("fill_pc", tg[i]);
    end
    chk_sp("full_sp", 3'd4);
    chk_flags("full_flags", 4'b1000);
    bus.pc_call = 1; bus.pc_next = 12'h7FF; step();
    chk_pc("ovf_pc", 12'h700); chk_sp("ovf_sp", 3'd4);
    chk_flags("ovf_flags", 4'b1010);
    bus.err_clr = 1; bus.flash_ready = 0; step();
    chk_flags("ovf_clr", 4'b1000);
    for (int i = 0; i < 4; i++) begin
      bus.pc_ret = 1; step();
      chk_pc("drain_pc", rp[i]);
    end
    chk_sp("drain_sp", 3'd0);
  endtask

  task automatic test_underflow();
    bus.pc_ret = 1; step();
    chk_pc("unf_pc", 12'h012); chk_sp("unf_sp", 3'd0);
    chk_flags("unf_flags", 4'b0101);
    bus.pc_ret = 1; bus.err_clr = 1; step();
    chk_flags("unf_set_wins", 4'b0101);
    bus.err_clr = 1; step();
    chk_flags("unf_clr", 4'b0100);
  endtask

  task automatic test_rel();
    bus.pc_load = 1; bus.pc_next = 12'h005; step();
    bus.pc_rel = 1; bus.pc_inc = 1; bus.rel_off = 8'hF8; step();
`ifdef PC_REL_BRANCH_EN
    chk_pc("rel_wrap", 12'hFFD);
    bus.pc_rel = 1; bus.rel_off = 8'h10; step();
    chk_pc("rel_fwd", 12'h00D);
`else
    chk_pc("rel_off_inc", 12'h006);
    bus.pc_rel = 1; bus.rel_off = 8'h10; step();
    chk_pc("rel_off_hold", 12'h006);
`endif
    bus.pc_load = 1; bus.pc_next = 12'hFFF; step();
    bus.pc_inc = 1; step();
    chk_pc("inc_wrap", 12'h000);
  endtask

  task automatic test_priority();
    bus.pc_load = 1; bus.pc_next = 12'h0AA; step();
    bus.pc_call = 1; bus.pc_next = 12'h123; step();
    chk_sp("prio_setup_sp", 3'd1);
    bus.pc_ret = 1; bus.pc_call = 1; bus.pc_load = 1;
    bus.pc_inc = 1; bus.pc_next = 12'h055; step();
    chk_pc("prio_pc", 12'h0AB); chk_sp("prio_sp", 3'd0);
    bus.pc_call = 1; bus.pc_load = 1; bus.pc_inc = 1;
    bus.pc_next = 12'h066; step();
    chk_pc("prio_call_pc", 12'h066); chk_sp("prio_call_sp", 3'd1);
    bus.pc_ret = 1; step();
    bus.pc_load = 1; bus.pc_inc = 1; bus.pc_next = 12'h077; step();
    chk_pc("prio_load_pc", 12'h077);
  endtask

  task automatic test_back_to_back();
    bus.pc_call = 1; bus.pc_next = 12'h300; step();
    chk_pc("b2b_call", 12'h300);
    bus.pc_ret = 1; step();
    chk_pc("b2b_ret", 12'h078); chk_sp("b2b_sp", 3'd0);
  endtask

  task automatic test_async_reset();
    bus.pc_ret = 1; step();
    bus.pc_call = 1; bus.pc_next = 12'h222; step();
    chk_flags("pre_arst_flags", 4'b0001);
    #2 arst_n = 0;
    #1;
    chk_pc("arst_pc", 12'h100);
    chk_sp("arst_sp", 3'd0);
    chk_flags("arst_flags", 4'b0100);
    @(negedge clk);
    arst_n = 1;
    bus.pc_inc = 1; step();
    chk_pc("post_arst_inc", 12'h101);
  endtask

  initial begin
    test_reset();
    test_inc();
    test_nested_call();
    test_depth();
    test_underflow();
    test_rel();
    test_priority();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
